// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and types for the register file with busy scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

  // Architectural zero register address.
  localparam int REG_ZERO = 0;

  typedef logic [AW_DEF-1:0]     rf_addr_t;
  typedef logic [DATA_W_DEF-1:0] rf_word_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file: read ports, write port,
// issue port and the scoreboard summary.
interface reg_file_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  localparam int AW      = $clog2(NUM_REGS)
) ();

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic                     busy_any;

  // Pipeline side (decode + writeback) drives addresses and data.
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_any
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_any
  );

endinterface

// File: rtl/reg_file_sb_read_port.sv
// One combinational read port: storage lookup, same-cycle write bypass,
// zero-register override and busy flag with writeback resolution.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic [DATA_W-1:0] entries [NUM_REGS],
  input  logic [NUM_REGS-1:0] busy,
  input  logic [AW-1:0]     rdAddr,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              rdBusy
);

  logic isZero;
  logic wrHit;

  // Lookup, then let an in-flight write win, then let register 0 win over everything.
  always_comb begin
    isZero = (ZERO_REG != 0) && (rdAddr == AW'(REG_ZERO));
    wrHit  = wrEn && (wrAddr == rdAddr);
    rdData = entries[rdAddr];
    rdBusy = busy[rdAddr];
    if (wrHit) begin
      rdData = wrData;
      rdBusy = 1'b0;
    end
    if (isZero) begin
      rdData = '0;
      rdBusy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised multi-read-port register file with per-register busy
// scoreboard. Storage is flops so the whole file clears asynchronously.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input logic ck,
  input logic rst,
  reg_file_sb_if.slave bus
);

  logic [DATA_W-1:0]   entries [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wrLive;

  // A write presented during reset must not leak through the bypass.
  assign wrLive = bus.wr_en & ~rst;

  genvar gi;

  for (gi = 0; gi < NUM_REGS; gi++) begin : gEntry
    if ((ZERO_REG != 0) && (gi == REG_ZERO)) begin : gZero
      assign entries[gi] = '0;
      assign busy[gi]    = 1'b0;
    end else begin : gLive
      logic [DATA_W-1:0] entryReg;
      logic              busyReg;
      logic              wrHit;
      logic              issHit;

      assign wrHit  = bus.wr_en && (bus.wr_addr == AW'(gi));
      assign issHit = bus.iss_en && (bus.iss_addr == AW'(gi));

      // Data capture plus busy set/clear; a new issue supersedes a same-edge writeback.
      always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
          entryReg <= '0;
          busyReg  <= 1'b0;
        end else begin
          if (wrHit) entryReg <= bus.wr_data;
          if (issHit)     busyReg <= 1'b1;
          else if (wrHit) busyReg <= 1'b0;
        end
      end

      assign entries[gi] = entryReg;
      assign busy[gi]    = busyReg;
    end
  end

  for (gi = 0; gi < NUM_RD; gi++) begin : gPort
    logic [DATA_W-1:0] portData;
    logic              portBusy;

    rf_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
    ) uPort (
      .entries (entries),
      .busy    (busy),
      .rdAddr  (bus.rd_addr[gi*AW +: AW]),
      .wrEn    (wrLive),
      .wrAddr  (bus.wr_addr),
      .wrData  (bus.wr_data),
      .rdData  (portData),
      .rdBusy  (portBusy)
    );

    assign bus.rd_data[gi*DATA_W +: DATA_W] = portData;
    assign bus.rd_busy[gi]                  = portBusy;
  end

  assign bus.busy_any = |busy;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-read-port register file for the 32-bit RISC datapath, with an integrated busy scoreboard.
- Replaces the fixed 2-read/1-write file:
  - configurable width, depth and read-port count;
  - register 0 hardwired to zero;
  - same-cycle write-to-read bypass;
  - asynchronous clear of all entries;
  - per-register busy bits so decode can stall on multi-cycle producers (loads, multiply).
- Sits between decode (read and issue side) and writeback (write side).

Parameters:
- DATA_W, 32, register data width in bits
- NUM_REGS, 32, number of architectural registers (power of 2, ≥4)
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and never goes busy
- AW, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
- ck  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- rd_addr  input  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW]
- rd_data  output  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
- rd_busy  output  NUM_RD  scoreboard busy flag for each read address
- wr_en  input  1  write strobe
- wr_addr  input  AW  write address
- wr_data  input  DATA_W  write data
- iss_en  input  1  issue of a multi-cycle producer; marks iss_addr busy
- iss_addr  input  AW  destination register of the issued producer
- busy_any  output  1  OR of all busy bits; used for pipeline-drain and flush checks

Behaviour:
- Reset: rst high asynchronously clears every register entry to 0 and every busy bit to 0.
  - While rst is high: rd_data = 0, rd_busy = 0, busy_any = 0, regardless of address.
  - Release is synchronous to the next ck edge; the first write is accepted on the first rising edge with rst low.
- Write: on rising ck with wr_en=1, entry[wr_addr] <= wr_data. Write latency is 1 cycle.
- Read: combinational, 0-cycle latency.
  - rd_data[i] = entry[rd_addr[i]], except for the two overrides below.
  - Bypass: if wr_en=1 and wr_addr==rd_addr[i] (and the address is not a suppressed register 0), rd_data[i] = wr_data in the same cycle.
  - Zero register: with ZERO_REG=1 and rd_addr[i]==0, rd_data[i] = 0 always. Writes to address 0 are dropped.
- Scoreboard:
  - On rising ck with iss_en=1, busy[iss_addr] <= 1.
  - On rising ck with wr_en=1, busy[wr_addr] <= 0.
  - Same register issued and written on the same edge: set wins, so busy stays 1 (new producer supersedes the old value).
  - Different registers on the same edge: both actions apply.
  - ZERO_REG=1: busy[0] is held at 0 and iss_addr==0 is ignored.
  - rd_busy[i] = busy[rd_addr[i]] & ~(wr_en & wr_addr==rd_addr[i]). The writeback in the current cycle resolves the hazard combinationally, consistent with the data bypass.
  - A write to a non-busy register is legal; its busy bit stays 0.
  - Issuing to an already-busy register is legal; the bit stays 1.
- Multiple read ports may address the same register; all return identical data and busy flags.
- Out-of-range addresses cannot occur because NUM_REGS = 2**AW.
- No internal FSM beyond the per-entry busy flops.
- Storage is flops, not inferred RAM, because of the asynchronous clear.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W and NUM_REGS defaults;
  - the REG_ZERO address constant;
  - an rf_addr_t typedef sized by AW;
  - a rf_word_t typedef sized by DATA_W.
- One natural sub-module: rf_read_port, instantiated NUM_RD times via generate. It takes the storage array, busy vector, read address and the write bypass inputs, and produces rd_data and rd_busy for one port.

Test Plan:
- Assert rst mid-operation after writing 0xDEADBEEF to r5 and issuing to r7 -> rd_data=0 and rd_busy=0 immediately, without waiting for ck; after release, r5 reads 0 and busy_any=0.
- Write 0x12345678 to r3 while rd_addr[0]=3 in the same cycle -> rd_data[0]=0x12345678 before the edge; after the edge r3 still reads 0x12345678 with wr_en=0.
- Write 0xFFFFFFFF to r0 with ZERO_REG=1, then read r0 on all ports -> 0; iss_en with iss_addr=0 -> busy_any stays 0.
- Issue r9, then idle 3 cycles -> rd_busy=1 for any port reading r9; write r9 with 0xA5A5A5A5 -> rd_busy=0 in that cycle, busy bit clear after the edge.
- Same edge iss_en to r4 and wr_en to r4 (r4 previously busy) -> r4 data updated and busy remains 1; same edge iss to r4 and write to r6 (r6 busy) -> r4 busy, r6 clear.
- NUM_RD=4, DATA_W=16, NUM_REGS=16: load all registers with index*0x0101, read addresses {15,0,7,7} -> {0x0F0F, 0x0000, 0x0707, 0x0707}.
